dcache_ctrl: RTL

Direct-mapped, write-back, write-allocate L1 data cache. It sits directly downstream of the EX/MEM pipeline register, in place of the single-cycle data memory. It serves MEM-stage loads and stores in the same cycle on a hit. On a miss it raises a stall to the whole pipeline and runs a line writeback and/or refill over a req/ack handshake to a slow 256-bit backing memory.

---
 rtl/dcache_pkg.sv | 33 +++
 rtl/dcache_array.sv | 60 ++++++
 rtl/dcache_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped write-back L1 data cache.
// Offset field is fixed at addr[4:0] (32-byte lines of eight 32-bit words).
package dcache_pkg;

   localparam int LINE_W = 256;
   localparam int WORD_W = 32;
   localparam int OFF_W  = 5;
   localparam int WSEL_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITEBACK = 2'd1,
      ST_ALLOCATE  = 2'd2
   } state_e;

   function automatic logic [WSEL_W-1:0] addr_word(input logic [31:0] addr);
      return WSEL_W'(addr >> 2);
   endfunction

   function automatic logic [31:0] addr_index(input logic [31:0] addr, input int index_w);
      return (addr >> OFF_W) & ((32'd1 << index_w) - 32'd1);
   endfunction

   function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int index_w);
      return addr >> (OFF_W + index_w);
   endfunction

   function automatic logic [31:0] line_addr(input logic [31:0] tag, input logic [31:0] index,
                                             input int index_w);
      return (tag << (OFF_W + index_w)) | (index << OFF_W);
   endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/dirty/tag/data storage: combinational read port, one write port (word store or line fill).
// Only valid and dirty are reset; tag and data keep whatever they held.
module dcache_array
   import dcache_pkg::*;
#(
   parameter int SETS    = 32,
   parameter int INDEX_W = $clog2(SETS),
   parameter int TAG_W   = 32 - OFF_W - INDEX_W
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [INDEX_W-1:0] rd_idx_i,
   output logic               rd_valid_o,
   output logic               rd_dirty_o,
   output logic [TAG_W-1:0]   rd_tag_o,
   output logic [LINE_W-1:0]  rd_line_o,
   input  logic [INDEX_W-1:0] wr_idx_i,
   input  logic               word_we_i,
   input  logic [WSEL_W-1:0]  wr_word_i,
   input  logic [WORD_W-1:0]  wr_wdata_i,
   input  logic               line_we_i,
   input  logic [TAG_W-1:0]   wr_tag_i,
   input  logic [LINE_W-1:0]  wr_line_i,
   input  logic               clean_i
);

   logic [SETS-1:0]   valid_q;
   logic [SETS-1:0]   dirty_q;
   logic [TAG_W-1:0]  tag_q  [SETS];
   logic [LINE_W-1:0] data_q [SETS];

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_dirty_o = dirty_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_line_o  = data_q[rd_idx_i];

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (line_we_i) begin
         valid_q[wr_idx_i] <= 1'b1;
         dirty_q[wr_idx_i] <= 1'b0;
      end else if (word_we_i) begin
         dirty_q[wr_idx_i] <= 1'b1;
      end else if (clean_i) begin
         dirty_q[wr_idx_i] <= 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (line_we_i) begin
         tag_q[wr_idx_i]  <= wr_tag_i;
         data_q[wr_idx_i] <= wr_line_i;
      end else if (word_we_i) begin
         data_q[wr_idx_i][wr_word_i*WORD_W +: WORD_W] <= wr_wdata_i;
      end
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate L1 D-cache: 0-cycle hits, stalls the pipeline on a miss
// while a victim writeback and/or line refill runs over a registered req/ack memory handshake.
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int SETS = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [31:0]       cpu_addr_i,
   input  logic [31:0]       cpu_wdata_i,
   input  logic              cpu_rd_i,
   input  logic              cpu_wr_i,
   output logic [31:0]       cpu_rdata_o,
   output logic              cpu_stall_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [31:0]       mem_addr_o,
   output logic [LINE_W-1:0] mem_wdata_o,
   input  logic [LINE_W-1:0] mem_rdata_i,
   input  logic              mem_ack_i
);

   localparam int INDEX_W = $clog2(SETS);
   localparam int TAG_W   = 32 - OFF_W - INDEX_W;

   state_e              state_q, state_d;
   logic [INDEX_W-1:0]  miss_idx_q, miss_idx_d;
   logic [TAG_W-1:0]    miss_tag_q, miss_tag_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [31:0]         mem_addr_q, mem_addr_d;
   logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;

   logic [INDEX_W-1:0]  cpu_idx;
   logic [TAG_W-1:0]    cpu_tag;
   logic [WSEL_W-1:0]   cpu_word;
   logic                rd_valid, rd_dirty;
   logic [TAG_W-1:0]    rd_tag;
   logic [LINE_W-1:0]   rd_line;
   logic                access, hit, idle, ack;
   logic                word_we, line_we, clean;

   assign cpu_idx  = INDEX_W'(addr_index(cpu_addr_i, INDEX_W));
   assign cpu_tag  = TAG_W'(addr_tag(cpu_addr_i, INDEX_W));
   assign cpu_word = addr_word(cpu_addr_i);

   assign access = cpu_rd_i | cpu_wr_i;
   assign hit    = rd_valid & (rd_tag == cpu_tag);
   assign idle   = (state_q == ST_IDLE);
   // An ack arriving without an outstanding request is dropped here.
   assign ack    = mem_ack_i & mem_req_q;

   dcache_array #(
      .SETS    (SETS),
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W)
   ) u_array (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .rd_idx_i   (cpu_idx),
      .rd_valid_o (rd_valid),
      .rd_dirty_o (rd_dirty),
      .rd_tag_o   (rd_tag),
      .rd_line_o  (rd_line),
      .wr_idx_i   (idle ? cpu_idx : miss_idx_q),
      .word_we_i  (word_we),
      .wr_word_i  (cpu_word),
      .wr_wdata_i (cpu_wdata_i),
      .line_we_i  (line_we),
      .wr_tag_i   (miss_tag_q),
      .wr_line_i  (mem_rdata_i),
      .clean_i    (clean)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= ST_IDLE;
         miss_idx_q  <= '0;
         miss_tag_q  <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         miss_idx_q  <= miss_idx_d;
         miss_tag_q  <= miss_tag_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:      if (access && !hit) state_d = (rd_valid && rd_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
         ST_WRITEBACK: if (ack) state_d = ST_ALLOCATE;
         ST_ALLOCATE:  if (ack) state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   // Memory-side outputs are computed one cycle ahead so they leave the block registered.
   always_comb begin
      miss_idx_d  = miss_idx_q;
      miss_tag_d  = miss_tag_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      word_we     = 1'b0;
      line_we     = 1'b0;
      clean       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            word_we = access & hit & cpu_wr_i;
            if (access && !hit) begin
               miss_idx_d = cpu_idx;
               miss_tag_d = cpu_tag;
               mem_req_d  = 1'b1;
               if (rd_valid && rd_dirty) begin
                  mem_we_d    = 1'b1;
                  mem_addr_d  = line_addr(32'(rd_tag), 32'(cpu_idx), INDEX_W);
                  mem_wdata_d = rd_line;
               end else begin
                  mem_we_d   = 1'b0;
                  mem_addr_d = line_addr(32'(cpu_tag), 32'(cpu_idx), INDEX_W);
               end
            end
         end
         ST_WRITEBACK: begin
            if (ack) begin
               clean     = 1'b1;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
            end
         end
         ST_ALLOCATE: begin
            if (ack) begin
               line_we   = 1'b1;
               mem_req_d = 1'b0;
            end else if (!mem_req_q) begin
               // Entered from writeback: request drops for one cycle before the refill issues.
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = line_addr(32'(miss_tag_q), 32'(miss_idx_q), INDEX_W);
            end
         end
         default: ;
      endcase
   end

   assign cpu_stall_o = rst_i & (~idle | (access & ~hit));
   assign cpu_rdata_o = (rst_i && idle && cpu_rd_i && !cpu_wr_i && hit)
                        ? rd_line[cpu_word*WORD_W +: WORD_W] : 32'd0;

   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;

endmodule
